// File: rtl/configurable_division.sv
// configurable_division: iterative signed divider with 8-bit, dual 8-bit and 16-bit modes.
// Non-restoring shift-subtract datapath, one quotient bit per clock, sign fix-up at the end.
// Optional feature macro: DIV_ZERO_BYPASS_EN (skip the iterations when every active divisor is zero).

module configurable_division #(
  parameter int LANE_W = 8
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                enable_i,
  input  logic [1:0]          cm_i,
  input  logic [2*LANE_W-1:0] dividend_i,
  input  logic [2*LANE_W-1:0] divisor_i,
  output logic [2*LANE_W-1:0] quotient_o,
  output logic [2*LANE_W-1:0] remainder_o,
  output logic [1:0]          div_by_zero_o,
  output logic                busy_o,
  output logic                data_valid_o
);

  localparam int LW = LANE_W;
  localparam int FW = 2 * LANE_W;
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] ITER_LANE = CW'(LW - 1);
  localparam logic [CW-1:0] ITER_FULL = CW'(FW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    cm_q, cm_d;
  logic [FW-1:0] dividend_q, dividend_d;
  logic [FW-1:0] divisor_q, divisor_d;
  logic [CW-1:0] count_q, count_d;

  // wide engine: full 16-bit operation, or the low lane in 8-bit modes
  logic [FW:0]   w_rem_q, w_rem_d;
  logic [FW-1:0] w_quo_q, w_quo_d;
  logic [FW-1:0] w_dvs_q, w_dvs_d;

  // narrow engine: high lane in dual 8-bit mode
  logic [LW:0]   n_rem_q, n_rem_d;
  logic [LW-1:0] n_quo_q, n_quo_d;
  logic [LW-1:0] n_dvs_q, n_dvs_d;

  logic [FW-1:0] quotient_q, quotient_d;
  logic [FW-1:0] remainder_q, remainder_d;
  logic [1:0]    dbz_q, dbz_d;

  logic start;

  logic [FW:0]   w_shift, w_step;
  logic [LW:0]   n_shift, n_step;
  logic [FW-1:0] w_rem_mag;
  logic [LW-1:0] n_rem_mag;

  logic [LW-1:0] lo_quot, lo_rem, hi_quot, hi_rem;
  logic [FW-1:0] full_quot, full_rem;
  logic          lo_zero, hi_zero, full_zero;

  function automatic logic [LW-1:0] abs_lane(input logic [LW-1:0] v);
    return v[LW-1] ? -v : v;
  endfunction

  function automatic logic [FW-1:0] abs_full(input logic [FW-1:0] v);
    return v[FW-1] ? -v : v;
  endfunction

  assign start = (state_q == S_IDLE) && enable_i && (cm_i != 2'b11);

  // one non-restoring step per engine: shift in the next dividend bit, then add or subtract the divisor
  always_comb begin
    w_shift   = {w_rem_q[FW-1:0], w_quo_q[FW-1]};
    w_step    = w_rem_q[FW] ? (w_shift + {1'b0, w_dvs_q}) : (w_shift - {1'b0, w_dvs_q});
    n_shift   = {n_rem_q[LW-1:0], n_quo_q[LW-1]};
    n_step    = n_rem_q[LW] ? (n_shift + {1'b0, n_dvs_q}) : (n_shift - {1'b0, n_dvs_q});
    w_rem_mag = w_rem_q[FW] ? (w_rem_q[FW-1:0] + w_dvs_q) : w_rem_q[FW-1:0];
    n_rem_mag = n_rem_q[LW] ? (n_rem_q[LW-1:0] + n_dvs_q) : n_rem_q[LW-1:0];
  end

  // signed lane results from the unsigned engine magnitudes, with divide-by-zero override
  always_comb begin
    lo_zero   = (divisor_q[LW-1:0] == '0);
    hi_zero   = (divisor_q[FW-1:LW] == '0);
    full_zero = (divisor_q == '0);
    lo_quot   = (dividend_q[LW-1] ^ divisor_q[LW-1]) ? -w_quo_q[LW-1:0] : w_quo_q[LW-1:0];
    lo_rem    = dividend_q[LW-1] ? -w_rem_mag[LW-1:0] : w_rem_mag[LW-1:0];
    hi_quot   = (dividend_q[FW-1] ^ divisor_q[FW-1]) ? -n_quo_q : n_quo_q;
    hi_rem    = dividend_q[FW-1] ? -n_rem_mag : n_rem_mag;
    full_quot = (dividend_q[FW-1] ^ divisor_q[FW-1]) ? -w_quo_q : w_quo_q;
    full_rem  = dividend_q[FW-1] ? -w_rem_mag : w_rem_mag;
    if (lo_zero) begin
      lo_quot = '1;
      lo_rem  = dividend_q[LW-1:0];
    end
    if (hi_zero) begin
      hi_quot = '1;
      hi_rem  = dividend_q[FW-1:LW];
    end
    if (full_zero) begin
      full_quot = '1;
      full_rem  = dividend_q;
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  logic all_zero;

  // every active lane has a zero divisor at capture time
  always_comb begin
    case (cm_i)
      2'b00:   all_zero = (divisor_i[LW-1:0] == '0);
      2'b01:   all_zero = (divisor_i[LW-1:0] == '0) && (divisor_i[FW-1:LW] == '0);
      2'b10:   all_zero = (divisor_i == '0);
      default: all_zero = 1'b0;
    endcase
  end
`endif

  // control sequencing: IDLE -> CALC -> FIX -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (count_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // operand capture, iteration and result registration
  always_comb begin
    cm_d        = cm_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    count_d     = count_q;
    w_rem_d     = w_rem_q;
    w_quo_d     = w_quo_q;
    w_dvs_d     = w_dvs_q;
    n_rem_d     = n_rem_q;
    n_quo_d     = n_quo_q;
    n_dvs_d     = n_dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cm_d       = cm_i;
          dividend_d = dividend_i;
          divisor_d  = divisor_i;
          w_rem_d    = '0;
          n_rem_d    = '0;
          n_quo_d    = abs_lane(dividend_i[FW-1:LW]);
          n_dvs_d    = abs_lane(divisor_i[FW-1:LW]);
          if (cm_i == 2'b10) begin
            count_d = ITER_FULL;
            w_quo_d = abs_full(dividend_i);
            w_dvs_d = abs_full(divisor_i);
          end else begin
            // the 8-bit lane sits in the top half so its bits shift out first
            count_d = ITER_LANE;
            w_quo_d = {abs_lane(dividend_i[LW-1:0]), {LW{1'b0}}};
            w_dvs_d = {{LW{1'b0}}, abs_lane(divisor_i[LW-1:0])};
          end
`ifdef DIV_ZERO_BYPASS_EN
          // a single token CALC cycle: the zero-divisor override in FIX ignores the engines
          if (all_zero) count_d = '0;
`endif
        end
      end
      S_CALC: begin
        w_rem_d = w_step;
        w_quo_d = {w_quo_q[FW-2:0], ~w_step[FW]};
        n_rem_d = n_step;
        n_quo_d = {n_quo_q[LW-2:0], ~n_step[LW]};
        if (count_q != '0) count_d = count_q - 1'b1;
      end
      S_FIX: begin
        case (cm_q)
          2'b10: begin
            quotient_d  = full_quot;
            remainder_d = full_rem;
            dbz_d       = {1'b0, full_zero};
          end
          2'b01: begin
            quotient_d  = {hi_quot, lo_quot};
            remainder_d = {hi_rem, lo_rem};
            dbz_d       = {hi_zero, lo_zero};
          end
          default: begin
            quotient_d  = {{LW{lo_quot[LW-1]}}, lo_quot};
            remainder_d = {{LW{lo_rem[LW-1]}}, lo_rem};
            dbz_d       = {1'b0, lo_zero};
          end
        endcase
      end
      default: ;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cm_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      count_q     <= '0;
      w_rem_q     <= '0;
      w_quo_q     <= '0;
      w_dvs_q     <= '0;
      n_rem_q     <= '0;
      n_quo_q     <= '0;
      n_dvs_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= '0;
    end else begin
      state_q     <= state_d;
      cm_q        <= cm_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      count_q     <= count_d;
      w_rem_q     <= w_rem_d;
      w_quo_q     <= w_quo_d;
      w_dvs_q     <= w_dvs_d;
      n_rem_q     <= n_rem_d;
      n_quo_q     <= n_quo_d;
      n_dvs_q     <= n_dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o        = (state_q != S_IDLE);
  assign data_valid_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_configurable_division.sv
// tb_configurable_division: directed self-checking bench for configurable_division.
// Honours DIV_ZERO_BYPASS_EN when computing expected latency of all-zero-divisor operations.

module tb_configurable_division;

  localparam int LAT8  = 9;
  localparam int LAT16 = 17;
`ifdef DIV_ZERO_BYPASS_EN
  localparam int LAT_DZ8  = 2;
  localparam int LAT_DZ16 = 2;
`else
  localparam int LAT_DZ8  = 9;
  localparam int LAT_DZ16 = 17;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  cm;
  logic [15:0] dividend, divisor;
  logic [15:0] quotient, remainder;
  logic [1:0]  dbz;
  logic        busy, valid;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic [15:0] q, r;
  logic [1:0]  z;
  logic        busy_low, dv_after;

  configurable_division #(.LANE_W(8)) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .enable_i     (enable),
    .cm_i         (cm),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(dbz),
    .busy_o       (busy),
    .data_valid_o (valid)
  );

  always #5 clk = ~clk;

  // start one operation and measure edges from accept to the valid pulse (-1 on timeout)
  task automatic do_op(input logic [1:0] c, input logic [15:0] dvd, input logic [15:0] dvs,
                       input bit disturb);
    bit found;
    @(negedge clk);
    enable = 1'b1; cm = c; dividend = dvd; divisor = dvs;
    @(posedge clk); #1;
    if (!disturb) enable = 1'b0;
    lat = 0; busy_low = 1'b0; found = 1'b0;
    while (lat < 40 && !found) begin
      if (disturb && lat == 3) begin
        dividend = 16'hFFFF; divisor = 16'h0001; cm = 2'b11;
      end
      if (disturb && lat == 5) enable = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_low = 1'b1;
      if (valid) found = 1'b1;
    end
    if (!found) lat = -1;
    q = quotient; r = remainder; z = dbz;
    @(posedge clk); #1;
    dv_after = valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; cm = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, dbz} !== 34'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got q=%h r=%h z=%b expected all 0", quotient, remainder, dbz);
    end
    checks++;
    if ({busy, valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_flags: got busy=%b valid=%b expected 0 0", busy, valid);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mode16();
    do_op(2'b10, 16'h8000, 16'h0003, 1'b0);
    checks++;
    if (lat !== LAT16 || busy_low || dv_after !== 1'b0) begin
      errors++; $display("[TB] FAIL m16_timing: got lat=%0d busy_low=%b dv_after=%b expected %0d 0 0", lat, busy_low, dv_after, LAT16);
    end
    checks++;
    if ({q, r, z} !== {16'hD556, 16'hFFFE, 2'b00}) begin
      errors++; $display("[TB] FAIL m16_result: got q=%h r=%h z=%b expected d556 fffe 00", q, r, z);
    end
  endtask

  task automatic test_mode8();
    do_op(2'b00, 16'h0064, 16'h00F9, 1'b0);
    checks++;
    if (lat !== LAT8 || busy_low || dv_after !== 1'b0) begin
      errors++; $display("[TB] FAIL m8_timing: got lat=%0d busy_low=%b dv_after=%b expected %0d 0 0", lat, busy_low, dv_after, LAT8);
    end
    checks++;
    if ({q, r, z} !== {16'hFFF2, 16'h0002, 2'b00}) begin
      errors++; $display("[TB] FAIL m8_result: got q=%h r=%h z=%b expected fff2 0002 00", q, r, z);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder} !== {16'hFFF2, 16'h0002}) begin
      errors++; $display("[TB] FAIL m8_hold: got q=%h r=%h expected fff2 0002", quotient, remainder);
    end
  endtask

  task automatic test_dual();
    do_op(2'b01, 16'h7FF6, 16'h0203, 1'b0);
    checks++;
    if (lat !== LAT8 || busy_low || dv_after !== 1'b0) begin
      errors++; $display("[TB] FAIL dual_timing: got lat=%0d busy_low=%b dv_after=%b expected %0d 0 0", lat, busy_low, dv_after, LAT8);
    end
    checks++;
    if ({q, r, z} !== {16'h3FFD, 16'h01FF, 2'b00}) begin
      errors++; $display("[TB] FAIL dual_result: got q=%h r=%h z=%b expected 3ffd 01ff 00", q, r, z);
    end
  endtask

  task automatic test_overflow();
    do_op(2'b01, 16'h8080, 16'hFFFF, 1'b0);
    checks++;
    if (lat !== LAT8 || {q, r, z} !== {16'h8080, 16'h0000, 2'b00}) begin
      errors++; $display("[TB] FAIL ovf_dual: got lat=%0d q=%h r=%h z=%b expected %0d 8080 0000 00", lat, q, r, z, LAT8);
    end
    do_op(2'b10, 16'h8000, 16'hFFFF, 1'b0);
    checks++;
    if (lat !== LAT16 || {q, r, z} !== {16'h8000, 16'h0000, 2'b00}) begin
      errors++; $display("[TB] FAIL ovf_16: got lat=%0d q=%h r=%h z=%b expected %0d 8000 0000 00", lat, q, r, z, LAT16);
    end
    do_op(2'b00, 16'h0080, 16'h00FF, 1'b0);
    checks++;
    if (lat !== LAT8 || {q, r, z} !== {16'hFF80, 16'h0000, 2'b00}) begin
      errors++; $display("[TB] FAIL ovf_8: got lat=%0d q=%h r=%h z=%b expected %0d ff80 0000 00", lat, q, r, z, LAT8);
    end
  endtask

  task automatic test_div_zero();
    do_op(2'b10, 16'h1234, 16'h0000, 1'b0);
    checks++;
    if (lat !== LAT_DZ16 || dv_after !== 1'b0) begin
      errors++; $display("[TB] FAIL dz16_timing: got lat=%0d dv_after=%b expected %0d 0", lat, dv_after, LAT_DZ16);
    end
    checks++;
    if ({q, r, z} !== {16'hFFFF, 16'h1234, 2'b01}) begin
      errors++; $display("[TB] FAIL dz16_result: got q=%h r=%h z=%b expected ffff 1234 01", q, r, z);
    end
    do_op(2'b01, 16'h50F9, 16'h0003, 1'b0);
    checks++;
    if (lat !== LAT8 || {q, r, z} !== {16'hFFFE, 16'h50FF, 2'b10}) begin
      errors++; $display("[TB] FAIL dz_hi_lane: got lat=%0d q=%h r=%h z=%b expected %0d fffe 50ff 10", lat, q, r, z, LAT8);
    end
    do_op(2'b00, 16'h00F0, 16'hAB00, 1'b0);
    checks++;
    if (lat !== LAT_DZ8 || {q, r, z} !== {16'hFFFF, 16'hFFF0, 2'b01}) begin
      errors++; $display("[TB] FAIL dz8: got lat=%0d q=%h r=%h z=%b expected %0d ffff fff0 01", lat, q, r, z, LAT_DZ8);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    @(negedge clk);
    enable = 1'b1; cm = 2'b10; dividend = 16'h0100; divisor = 16'h0003;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, dbz, busy, valid} !== 36'd0) begin
      errors++; $display("[TB] FAIL abort_clear: got q=%h r=%h z=%b busy=%b valid=%b expected all 0", quotient, remainder, dbz, busy, valid);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_no_valid: got activity=%b expected 0", seen);
    end
    do_op(2'b10, 16'h0007, 16'h0002, 1'b0);
    checks++;
    if (lat !== LAT16 || {q, r, z} !== {16'h0003, 16'h0001, 2'b00}) begin
      errors++; $display("[TB] FAIL abort_restart: got lat=%0d q=%h r=%h z=%b expected %0d 0003 0001 00", lat, q, r, z, LAT16);
    end
  endtask

  task automatic test_input_changes();
    do_op(2'b10, 16'h1234, 16'h0010, 1'b1);
    checks++;
    if (lat !== LAT16 || busy_low || {q, r, z} !== {16'h0123, 16'h0004, 2'b00}) begin
      errors++; $display("[TB] FAIL inputs_change: got lat=%0d busy_low=%b q=%h r=%h z=%b expected %0d 0 0123 0004 00", lat, busy_low, q, r, z, LAT16);
    end
  endtask

  task automatic test_reserved();
    bit seen;
    @(negedge clk);
    enable = 1'b1; cm = 2'b11; dividend = 16'h0042; divisor = 16'h0005;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy || valid) seen = 1'b1;
    end
    enable = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL reserved_mode: got activity=%b expected 0", seen);
    end
    checks++;
    if (quotient !== 16'h0123) begin
      errors++; $display("[TB] FAIL reserved_hold: got q=%h expected 0123", quotient);
    end
  endtask

  task automatic test_back_to_back();
    int edge_n;
    int first, second;
    @(negedge clk);
    enable = 1'b1; cm = 2'b00; dividend = 16'h0064; divisor = 16'h0003;
    @(posedge clk); #1;
    edge_n = 0; first = -1; second = -1;
    while (edge_n < 60 && second < 0) begin
      @(posedge clk); #1;
      edge_n++;
      if (valid) begin
        if (first < 0) first = edge_n;
        else second = edge_n;
      end
    end
    enable = 1'b0;
    checks++;
    if (first !== 9 || second !== 20) begin
      errors++; $display("[TB] FAIL b2b_timing: got first=%0d second=%0d expected 9 20", first, second);
    end
    checks++;
    if ({quotient, remainder, dbz} !== {16'h0021, 16'h0001, 2'b00}) begin
      errors++; $display("[TB] FAIL b2b_result: got q=%h r=%h z=%b expected 0021 0001 00", quotient, remainder, dbz);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_mode16();
    test_mode8();
    test_dual();
    test_overflow();
    test_div_zero();
    test_reset_abort();
    test_input_changes();
    test_reserved();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
